// File: rtl/b64to8.sv
// b64to8: unpacks 64-bit FIFO words (three flag bits, a 13-bit sextet index and
// six sample bytes) into a byte stream with valid/ready handshake, frame
// markers and sextet sequence checking.
module b64to8 #(
    parameter int SEQ_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    input  logic [63:0] fifo_data,
    input  logic [12:0] frame_length,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_adc_sel,
    output logic        out_shift,
    output logic        out_switch,
    output logic        seq_error,
    output logic [15:0] err_count,
    output logic [23:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2,
        EMIT = 2'd3
    } state_t;

    localparam bit CHECK_ON = (SEQ_CHECK != 0);

    state_t      state_reg;
    state_t      state_next;
    logic [63:0] word_reg;
    logic [2:0]  idx_reg;
    logic [12:0] flen_reg;
    logic [12:0] exp_reg;
    logic        adc_sel_reg;
    logic        shift_reg;
    logic        switch_reg;
    logic        seq_error_reg;
    logic [15:0] err_count_reg;
    logic [23:0] frame_count_reg;

    logic [12:0] idx_w;
    logic [12:0] word_idx;
    logic        capt;
    logic        accept;
    logic        mismatch;

    // Incoming sextet index is checked while the FIFO presents the word;
    // anything beyond the frame end is a mismatch even if it equals exp.
    assign idx_w    = fifo_data[60:48];
    assign word_idx = word_reg[60:48];
    assign capt     = (state_reg == CAPT);
    assign mismatch = (idx_w != exp_reg) || (idx_w > frame_length);

    assign out_valid = (state_reg == EMIT);
    assign accept    = out_valid && out_ready;
    assign out_data  = word_reg[{idx_reg, 3'b000} +: 8];
    assign out_sof   = out_valid && (idx_reg == 3'd0) && (word_idx == 13'd0);
    assign out_eof   = out_valid && (idx_reg == 3'd5) && (word_idx == flen_reg);

    assign out_adc_sel = adc_sel_reg;
    assign out_shift   = shift_reg;
    assign out_switch  = switch_reg;
    assign seq_error   = seq_error_reg;
    assign err_count   = err_count_reg;
    assign frame_count = frame_count_reg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and FIFO read strobe (one cycle, only from READ)
    always_comb begin
        state_next = state_reg;
        fifo_rd    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = READ;
                end
            end
            READ: begin
                fifo_rd    = 1'b1;
                state_next = CAPT;
            end
            CAPT: begin
                state_next = EMIT;
            end
            EMIT: begin
                if (out_ready && (idx_reg == 3'd5)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word capture, flag bits, frame length sample and byte index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg    <= 64'd0;
            adc_sel_reg <= 1'b0;
            shift_reg   <= 1'b0;
            switch_reg  <= 1'b0;
            flen_reg    <= 13'd0;
            idx_reg     <= 3'd0;
        end else if (capt) begin
            word_reg    <= fifo_data;
            adc_sel_reg <= fifo_data[63];
            shift_reg   <= fifo_data[62];
            switch_reg  <= fifo_data[61];
            flen_reg    <= frame_length;
            idx_reg     <= 3'd0;
        end else if (accept) begin
            idx_reg     <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
        end
    end

    // Sequence tracking: exp always resynchronises to the received index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_reg       <= 13'd0;
            seq_error_reg <= 1'b0;
            err_count_reg <= 16'd0;
        end else begin
            seq_error_reg <= CHECK_ON && capt && mismatch;
            if (capt) begin
                exp_reg <= (idx_w == frame_length) ? 13'd0 : idx_w + 13'd1;
                if (CHECK_ON && mismatch && (err_count_reg != 16'hFFFF)) begin
                    err_count_reg <= err_count_reg + 16'd1;
                end
            end
        end
    end

    // Completed frames are counted when the end-of-frame byte is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_reg <= 24'd0;
        end else if (accept && out_eof) begin
            frame_count_reg <= frame_count_reg + 24'd1;
        end
    end

endmodule

// File: tb/tb_b64to8.sv
// Scoreboard bench for b64to8: the stimulus process queues expected bytes,
// a monitor pops and compares every accepted byte.
module tb_b64to8;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [63:0] fifo_data;
    logic [12:0] frame_length;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eof;
    logic        out_adc_sel;
    logic        out_shift;
    logic        out_switch;
    logic        seq_error;
    logic [15:0] err_count;
    logic [23:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_q[$];   // {sof, eof, data}

    b64to8 #(.SEQ_CHECK(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd      (fifo_rd),
        .fifo_data    (fifo_data),
        .frame_length (frame_length),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .out_adc_sel  (out_adc_sel),
        .out_shift    (out_shift),
        .out_switch   (out_switch),
        .seq_error    (seq_error),
        .err_count    (err_count),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] mk(input logic [2:0] flags, input logic [12:0] idx,
                                       input logic [47:0] data);
        return {flags, idx, data};
    endfunction

    // Queue the first n bytes of a word with their frame markers
    task automatic push_word(input logic [63:0] w, input logic [12:0] fl, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == 0) && (w[60:48] == 13'd0),
                             (i == 5) && (w[60:48] == fl),
                             w[i*8 +: 8]});
        end
    endtask

    // Offer one word; return in the cycle the DUT captures it
    task automatic send_word(input logic [63:0] w);
        int n;
        n = 0;
        fifo_empty = 1'b0;
        while (!fifo_rd && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!fifo_rd) begin
            n_checks++;
            n_fail++;
            $display("FAIL fifo_rd_timeout: got 0 required 1");
        end
        @(posedge clk); #1;
        fifo_data  = w;
        fifo_empty = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d queued required 0", exp_q.size());
        end
    endtask

    // Monitor: every accepted byte must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got %0h required none", out_data);
            end else begin
                check("byte", {out_sof, out_eof, out_data}, exp_q.pop_front());
            end
        end
    end

    logic [7:0] prev;
    logic       pat [8];

    initial begin
        rst          = 1'b1;
        fifo_empty   = 1'b1;
        fifo_data    = 64'd0;
        frame_length = 13'd2;
        out_ready    = 1'b1;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs",
              {fifo_rd, out_valid, out_sof, out_eof, seq_error, out_adc_sel, out_shift, out_switch, out_data},
              16'h0000);
        check("rst_err_count", err_count, 0);
        check("rst_frame_count", frame_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // One complete frame of three sextets
        frame_length = 13'd2;
        for (int k = 0; k < 3; k++) begin
            push_word(mk(3'b000, 13'(k), 48'hA5_B4_C3_D2_E1_F0 + 48'(k * 48'h111111)), 13'd2, 6);
        end
        for (int k = 0; k < 3; k++) begin
            send_word(mk(3'b000, 13'(k), 48'hA5_B4_C3_D2_E1_F0 + 48'(k * 48'h111111)));
        end
        wait_drain();
        check("frame_count_1", frame_count, 1);
        check("err_count_0", err_count, 0);

        // Flag bits and byte order, plus three-cycle latency from IDLE
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({i == 0, 1'b0, 8'(i + 1)});
        end
        send_word(64'hE000_0605_0403_0201);
        @(posedge clk); #1;
        check("latency_valid", out_valid, 1);
        check("flags", {out_adc_sel, out_shift, out_switch}, 3'b111);
        wait_drain();

        // Backpressure: no loss or duplication, stable data, no early read
        push_word(mk(3'b010, 13'd1, 48'h16_15_14_13_12_11), 13'd2, 6);
        send_word(mk(3'b010, 13'd1, 48'h16_15_14_13_12_11));
        @(posedge clk); #1;
        fifo_empty = 1'b0;
        prev = out_data;
        for (int k = 0; k < 8; k++) begin
            out_ready = pat[k];
            if (out_valid) check("rd_hold", fifo_rd, 0);
            if (k > 0 && !pat[k-1]) check("stall_stable", out_data, prev);
            prev = out_data;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push_word(mk(3'b000, 13'd2, 48'h26_25_24_23_22_21), 13'd2, 6);
        send_word(mk(3'b000, 13'd2, 48'h26_25_24_23_22_21));
        wait_drain();
        check("frame_count_2", frame_count, 2);

        // Skipped sextet: error at index 3, resync to 0 without a second error
        frame_length = 13'd3;
        push_word(mk(3'b000, 13'd0, 48'h35_34_33_32_31_30), 13'd3, 6);
        send_word(mk(3'b000, 13'd0, 48'h35_34_33_32_31_30));
        push_word(mk(3'b000, 13'd1, 48'h45_44_43_42_41_40), 13'd3, 6);
        send_word(mk(3'b000, 13'd1, 48'h45_44_43_42_41_40));
        push_word(mk(3'b000, 13'd3, 48'h55_54_53_52_51_50), 13'd3, 6);
        send_word(mk(3'b000, 13'd3, 48'h55_54_53_52_51_50));
        @(posedge clk); #1;
        check("seq_error_pulse", seq_error, 1);
        @(posedge clk); #1;
        check("seq_error_one_cycle", seq_error, 0);
        check("err_count_1", err_count, 1);
        wait_drain();
        check("frame_count_3", frame_count, 3);
        push_word(mk(3'b000, 13'd0, 48'h65_64_63_62_61_60), 13'd3, 6);
        send_word(mk(3'b000, 13'd0, 48'h65_64_63_62_61_60));
        @(posedge clk); #1;
        check("resync_no_error", seq_error, 0);
        wait_drain();
        check("err_count_still_1", err_count, 1);

        // Index beyond frame end: flagged, next exp is 5001
        frame_length = 13'd100;
        push_word(mk(3'b000, 13'd5000, 48'h75_74_73_72_71_70), 13'd100, 6);
        send_word(mk(3'b000, 13'd5000, 48'h75_74_73_72_71_70));
        @(posedge clk); #1;
        check("beyond_end_error", seq_error, 1);
        wait_drain();
        check("err_count_2", err_count, 2);
        frame_length = 13'd6000;
        push_word(mk(3'b000, 13'd5001, 48'h85_84_83_82_81_80), 13'd6000, 6);
        send_word(mk(3'b000, 13'd5001, 48'h85_84_83_82_81_80));
        @(posedge clk); #1;
        check("exp_5001_match", seq_error, 0);
        wait_drain();
        check("err_count_still_2", err_count, 2);

        // Saturation: preload the counter just below its ceiling
        force dut.err_count_reg = 16'hFFFD;
        @(posedge clk); #1;
        release dut.err_count_reg;
        frame_length = 13'd100;
        for (int k = 0; k < 3; k++) begin
            push_word(mk(3'b000, 13'd200, 48'h95_94_93_92_91_90), 13'd100, 6);
            send_word(mk(3'b000, 13'd200, 48'h95_94_93_92_91_90));
            wait_drain();
            check("err_count_sat", err_count, (k == 0) ? 16'hFFFE : 16'hFFFF);
        end

        // Reset in the middle of a word: remaining bytes are dropped
        push_word(mk(3'b111, 13'd7, 48'hB5_B4_B3_B2_B1_B0), 13'd100, 3);
        send_word(mk(3'b111, 13'd7, 48'hB5_B4_B3_B2_B1_B0));
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_idx3", out_data, 8'hB3);
        rst = 1'b1;
        #2;
        check("mid_reset_outputs",
              {fifo_rd, out_valid, out_sof, out_eof, seq_error, out_adc_sel, out_shift, out_switch, out_data},
              16'h0000);
        check("mid_reset_counts", {err_count, frame_count}, 40'd0);
        check("dropped_bytes", exp_q.size(), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        frame_length = 13'd2;
        push_word(mk(3'b000, 13'd0, 48'hC5_C4_C3_C2_C1_C0), 13'd2, 6);
        send_word(mk(3'b000, 13'd0, 48'hC5_C4_C3_C2_C1_C0));
        @(posedge clk); #1;
        check("post_reset_exp0", seq_error, 0);
        wait_drain();
        check("post_reset_err", err_count, 0);
        check("post_reset_frames", frame_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
